// File: rtl/spram_ctrl.sv
// Controller for a single-port RAM: arbitrates a write and a read request channel
// onto one shared RAM port, with range checking and a registered read-capture path.
module spram_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int ADDR  = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_valid,
  input  logic [ADDR-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_valid_in,
  input  logic [ADDR-1:0]  rd_addr,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             addr_err,
  output logic             busy,
  output logic             ram_cs,
  output logic             ram_wr,
  output logic [ADDR-1:0]  ram_addr,
  inout  wire  [WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_t;

  state_t           state;
  logic             prio_wr;
  logic             drive;
  logic [WIDTH-1:0] wdata_q;
  logic             idle;
  logic             both;
  logic             grant_wr;
  logic             grant_rd;
  logic             wr_oob;
  logic             rd_oob;

  assign idle = (state == IDLE);
  assign both = wr_valid && rd_valid_in;

  // The losing channel only sees ready drop when both are contending.
  assign wr_ready = idle && rstn && !(both && !prio_wr);
  assign rd_ready = idle && rstn && !(both && prio_wr);
  assign grant_wr = wr_valid && wr_ready;
  assign grant_rd = rd_valid_in && rd_ready;

  assign wr_oob = 32'(wr_addr) >= 32'(DEPTH);
  assign rd_oob = 32'(rd_addr) >= 32'(DEPTH);

  assign busy     = !idle;
  assign ram_data = drive ? wdata_q : 'z;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      prio_wr  <= 1'b1;
      drive    <= 1'b0;
      wdata_q  <= '0;
      ram_cs   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_addr <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          // Alternation only advances on contended edges, even if the winner is rejected.
          if (both) prio_wr <= !prio_wr;
          if (grant_wr) begin
            if (wr_oob) begin
              addr_err <= 1'b1;
            end else begin
              ram_addr <= wr_addr;
              wdata_q  <= wr_data;
              ram_cs   <= 1'b1;
              ram_wr   <= 1'b1;
              drive    <= 1'b1;
              state    <= WR;
            end
          end else if (grant_rd) begin
            if (rd_oob) begin
              addr_err <= 1'b1;
            end else begin
              ram_addr <= rd_addr;
              ram_cs   <= 1'b1;
              ram_wr   <= 1'b0;
              state    <= RD;
            end
          end
        end
        WR: begin
          ram_cs <= 1'b0;
          ram_wr <= 1'b0;
          drive  <= 1'b0;
          state  <= IDLE;
        end
        RD: begin
          state <= RD_CAP;
        end
        RD_CAP: begin
          // The RAM drives the bus in this cycle, so capture as we leave.
          rd_data  <= ram_data;
          rd_valid <= 1'b1;
          ram_cs   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// Directed bench for spram_ctrl: a default instance with a behavioural RAM on its
// bus, and a DEPTH=48 instance for out-of-range handling.
module tb_spram_ctrl;

  logic       clk = 1'b0;
  logic       rstn;

  logic       wr_valid, rd_valid_in;
  logic [5:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic       wr_ready, rd_ready, rd_valid, addr_err, busy, ram_cs, ram_wr;
  logic [7:0] rd_data;
  logic [5:0] ram_addr;
  wire  [7:0] ram_data;

  logic       b_wr_valid, b_rd_valid_in;
  logic [5:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data;
  logic       b_wr_ready, b_rd_ready, b_rd_valid, b_addr_err, b_busy, b_ram_cs, b_ram_wr;
  logic [7:0] b_rd_data;
  logic [5:0] b_ram_addr;
  wire  [7:0] b_ram_data;

  int checks = 0;
  int fails = 0;
  int errPulses = 0;
  int rdValidPulses = 0;
  int cs48High = 0;
  int rdv48Pulses = 0;

  always #5 clk = ~clk;

  spram_ctrl #(.WIDTH(8), .DEPTH(64), .ADDR(6)) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid_in(rd_valid_in), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .addr_err(addr_err), .busy(busy),
    .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  spram_ctrl #(.WIDTH(8), .DEPTH(48), .ADDR(6)) dut48 (
    .clk(clk), .rstn(rstn),
    .wr_valid(b_wr_valid), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
    .rd_valid_in(b_rd_valid_in), .rd_addr(b_rd_addr), .rd_ready(b_rd_ready),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .addr_err(b_addr_err), .busy(b_busy),
    .ram_cs(b_ram_cs), .ram_wr(b_ram_wr), .ram_addr(b_ram_addr), .ram_data(b_ram_data)
  );

  // Behavioural single-port RAM; an undriven bus reads back as all ones.
  logic [7:0] mem [64];
  logic       ramDrive;
  logic [7:0] ramQ;

  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_data;
    ramDrive <= ram_cs && !ram_wr;
    ramQ     <= mem[ram_addr];
  end

  assign ram_data = ramDrive ? ramQ : 'z;
  pullup (ram_data);
  pullup (b_ram_data);

  always @(negedge clk) begin
    if (addr_err)   errPulses++;
    if (rd_valid)   rdValidPulses++;
    if (b_ram_cs)   cs48High++;
    if (b_rd_valid) rdv48Pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [5:0] wa, input logic [7:0] wd,
                               input logic rv, input logic [5:0] ra);
    wr_valid    = wv;
    wr_addr     = wa;
    wr_data     = wd;
    rd_valid_in = rv;
    rd_addr     = ra;
  endtask

  task automatic doWrite(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    applyStimulus(1'b1, a, d, 1'b0, 6'd0);
    #1;
    checkOutput("wr_ready", 32'(wr_ready), 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("wr_busy", 32'(busy), 1);
    checkOutput("wr_cs", 32'(ram_cs), 1);
    checkOutput("wr_we", 32'(ram_wr), 1);
    checkOutput("wr_ram_addr", 32'(ram_addr), 32'(a));
    checkOutput("wr_bus", 32'(ram_data), 32'(d));
    @(negedge clk);
    checkOutput("wr_done_cs", 32'(ram_cs), 0);
    checkOutput("wr_done_busy", 32'(busy), 0);
    checkOutput("wr_done_bus_z", 32'(ram_data), 32'hFF);
  endtask

  task automatic doRead(input logic [5:0] a, input logic [7:0] exp);
    @(negedge clk);
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1, a);
    #1;
    checkOutput("rd_ready", 32'(rd_ready), 1);
    @(posedge clk);
    #1;
    rd_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("rd_busy", 32'(busy), 1);
    checkOutput("rd_cs", 32'(ram_cs), 1);
    checkOutput("rd_we", 32'(ram_wr), 0);
    checkOutput("rd_bus_z", 32'(ram_data), 32'hFF);
    checkOutput("rd_early_valid", 32'(rd_valid), 0);
    @(negedge clk);
    checkOutput("rdcap_cs", 32'(ram_cs), 1);
    checkOutput("rdcap_busy", 32'(busy), 1);
    checkOutput("rdcap_valid", 32'(rd_valid), 0);
    @(negedge clk);
    checkOutput("rd_valid", 32'(rd_valid), 1);
    checkOutput("rd_data", 32'(rd_data), 32'(exp));
    checkOutput("rd_idle", 32'(busy), 0);
    @(negedge clk);
    checkOutput("rd_valid_pulse", 32'(rd_valid), 0);
    checkOutput("rd_data_hold", 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int e0, v0, c0;
    rstn = 1'b0;
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b0, 6'd0);
    b_wr_valid = 1'b0; b_wr_addr = 6'd0; b_wr_data = 8'd0;
    b_rd_valid_in = 1'b0; b_rd_addr = 6'd0;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_cs", 32'(ram_cs), 0);
    checkOutput("rst_we", 32'(ram_wr), 0);
    checkOutput("rst_addr", 32'(ram_addr), 0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 0);
    checkOutput("rst_rd_data", 32'(rd_data), 0);
    checkOutput("rst_addr_err", 32'(addr_err), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 0);
    checkOutput("rst_rd_ready", 32'(rd_ready), 0);
    checkOutput("rst_bus_z", 32'(ram_data), 32'hFF);
    rstn = 1'b1;
    #1;
    checkOutput("post_rst_wr_ready", 32'(wr_ready), 1);
    checkOutput("post_rst_rd_ready", 32'(rd_ready), 1);

    // Basic write/read, then the top address.
    doWrite(6'd0, 8'hA5);
    doRead(6'd0, 8'hA5);
    e0 = errPulses;
    doWrite(6'd63, 8'h3C);
    doRead(6'd63, 8'h3C);
    checkOutput("top_addr_no_err", 32'(errPulses - e0), 0);

    // First contended pair goes to write; the read then sees the new data.
    @(negedge clk);
    applyStimulus(1'b1, 6'd5, 8'h11, 1'b1, 6'd5);
    #1;
    checkOutput("sim1_wr_ready", 32'(wr_ready), 1);
    checkOutput("sim1_rd_ready", 32'(rd_ready), 0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("sim1_wr_state", 32'(ram_wr), 1);
    checkOutput("sim1_rd_blocked", 32'(rd_ready), 0);
    @(negedge clk);
    checkOutput("sim1_rd_ready_idle", 32'(rd_ready), 1);
    @(posedge clk);
    #1;
    rd_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("sim1_rd_valid", 32'(rd_valid), 1);
    checkOutput("sim1_rd_data", 32'(rd_data), 32'h11);

    // Second contended pair goes to read, which still returns the old word.
    @(negedge clk);
    applyStimulus(1'b1, 6'd6, 8'h22, 1'b1, 6'd5);
    #1;
    checkOutput("sim2_rd_ready", 32'(rd_ready), 1);
    checkOutput("sim2_wr_ready", 32'(wr_ready), 0);
    @(posedge clk);
    #1;
    rd_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("sim2_rd_state", 32'(ram_wr), 0);
    checkOutput("sim2_rd_cs", 32'(ram_cs), 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("sim2_rd_valid", 32'(rd_valid), 1);
    checkOutput("sim2_rd_data", 32'(rd_data), 32'h11);
    checkOutput("sim2_wr_ready_idle", 32'(wr_ready), 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("sim2_wr_state", 32'(ram_wr), 1);
    checkOutput("sim2_wr_bus", 32'(ram_data), 32'h22);
    @(negedge clk);
    doRead(6'd6, 8'h22);

    // Back-to-back writes then reads.
    for (int i = 0; i < 4; i++) doWrite(6'(10 + i), 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) doRead(6'(10 + i), 8'(8'h20 + i));

    // Reset in the middle of a read aborts it.
    v0 = rdValidPulses;
    @(negedge clk);
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1, 6'd10);
    @(posedge clk);
    #1;
    rd_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("abort_pre_cs", 32'(ram_cs), 1);
    rstn = 1'b0;
    #1;
    checkOutput("abort_cs", 32'(ram_cs), 0);
    checkOutput("abort_rd_data", 32'(rd_data), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_bus_z", 32'(ram_data), 32'hFF);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(rd_ready), 1);
    repeat (3) @(negedge clk);
    checkOutput("abort_no_valid", 32'(rdValidPulses - v0), 0);
    doRead(6'd10, 8'h20);

    // DEPTH=48 instance: rejected requests still handshake and use their turn.
    c0 = cs48High;
    @(negedge clk);
    b_wr_valid = 1'b1; b_wr_addr = 6'd50; b_wr_data = 8'h77;
    #1;
    checkOutput("oob_wr_ready", 32'(b_wr_ready), 1);
    @(posedge clk);
    #1;
    b_wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("oob_err", 32'(b_addr_err), 1);
    checkOutput("oob_busy", 32'(b_busy), 0);
    checkOutput("oob_cs", 32'(b_ram_cs), 0);
    @(negedge clk);
    checkOutput("oob_err_pulse", 32'(b_addr_err), 0);

    @(negedge clk);
    b_wr_valid = 1'b1; b_wr_addr = 6'd50; b_rd_valid_in = 1'b1; b_rd_addr = 6'd60;
    #1;
    checkOutput("oob_sim1_wr_ready", 32'(b_wr_ready), 1);
    checkOutput("oob_sim1_rd_ready", 32'(b_rd_ready), 0);
    @(posedge clk);
    #1;
    b_wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("oob_sim1_err", 32'(b_addr_err), 1);
    checkOutput("oob_sim1_rd_ready_now", 32'(b_rd_ready), 1);
    @(posedge clk);
    #1;
    b_rd_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("oob_rd_err", 32'(b_addr_err), 1);

    @(negedge clk);
    b_wr_valid = 1'b1; b_wr_addr = 6'd2; b_rd_valid_in = 1'b1; b_rd_addr = 6'd60;
    #1;
    checkOutput("oob_sim2_rd_ready", 32'(b_rd_ready), 1);
    checkOutput("oob_sim2_wr_ready", 32'(b_wr_ready), 0);
    @(posedge clk);
    #1;
    b_wr_valid = 1'b0;
    b_rd_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("oob_sim2_err", 32'(b_addr_err), 1);
    @(negedge clk);
    checkOutput("oob_never_cs", 32'(cs48High - c0), 0);
    checkOutput("oob_no_rd_valid", 32'(rdv48Pulses), 0);
    checkOutput("oob_rd_data", 32'(b_rd_data), 0);
    checkOutput("oob_we", 32'(b_ram_wr), 0);
    checkOutput("oob_bus_z", 32'(b_ram_data), 32'hFF);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/spram_ctrl.md
SPRAM_CTRL -- requirements
Module: spram_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning the number of RAM words.
REQ-003 The block SHALL have parameter ADDR, default 6, meaning the address width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have ports wr_valid (input, 1), wr_addr (input, ADDR) and wr_data (input, WIDTH), forming the write request channel.
REQ-007 The block SHALL have port wr_ready, output, 1 bit: a write transfers on a rising edge where wr_valid and wr_ready are both 1.
REQ-008 The block SHALL have ports rd_valid_in (input, 1) and rd_addr (input, ADDR), forming the read request channel.
REQ-009 The block SHALL have port rd_ready, output, 1 bit: a read transfers on a rising edge where rd_valid_in and rd_ready are both 1.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: a one-cycle pulse marking rd_data valid.
REQ-011 The block SHALL have port rd_data, output, WIDTH bits: the captured read word.
REQ-012 The block SHALL have port addr_err, output, 1 bit: a one-cycle pulse marking a rejected out-of-range request.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-014 The block SHALL have ports ram_cs, ram_wr (outputs, 1 each), ram_addr (output, ADDR) and ram_data (inout, WIDTH), which connect directly to the single-port RAM's cs, wr, addr and data.

Function
REQ-015 The RAM contract SHALL be: the RAM samples cs/wr/addr/data on the rising clock edge; if cs=1 and wr=1 it writes; if cs=1 and wr=0 it drives the data bus during the following cycle.
REQ-016 The FSM SHALL have states IDLE, WR, RD and RD_CAP.
REQ-017 wr_ready and rd_ready SHALL both be 1 only in IDLE with rstn=1; at most one request SHALL transfer per edge.
REQ-018 If only one channel is valid in IDLE, that channel SHALL be granted.
REQ-019 If both channels are valid in IDLE, the grant SHALL alternate, and the first simultaneous grant after reset SHALL go to write.
REQ-020 The ungranted channel's ready SHALL be 0 on that edge.
REQ-021 On grant, addr/data SHALL be registered internally, and the state SHALL go IDLE→WR for a write and IDLE→RD for a read.
REQ-022 In WR, ram_cs=1, ram_wr=1 and ram_data SHALL be driven with the registered data for exactly one cycle, followed by IDLE; write occupancy is one cycle after the accept edge.
REQ-023 In RD, ram_cs=1 and ram_wr=0 with ram_data high-Z, followed by RD_CAP; in RD_CAP, ram_cs=1 and ram_wr=0 SHALL be held with the bus high-Z.
REQ-024 At the end of RD_CAP, ram_data SHALL be captured into rd_data and rd_valid=1 for one cycle while the state returns to IDLE.
REQ-025 Read accepted at edge E SHALL yield rd_valid high in cycle E+2..E+3.
REQ-026 rd_data SHALL hold its value until the next capture.
REQ-027 ram_data SHALL be driven only in WR and be high-Z in every other state, including during reset.
REQ-028 ram_cs SHALL be 0 in IDLE, and ram_addr SHALL hold the last registered address.
REQ-029 A request with address >= DEPTH SHALL be accepted (ready handshake completes), generate no RAM access, pulse addr_err for one cycle, and leave the state in IDLE.
REQ-030 A rejected request SHALL still consume its arbitration turn, and a rejected read SHALL NOT pulse rd_valid.
REQ-031 Address arithmetic SHALL use no wrap-around; ADDR-bit inputs are compared unsigned against DEPTH.
REQ-032 wr_valid or rd_valid_in changing while the block is busy SHALL have no effect until IDLE.

Reset
REQ-033 On rstn=0, asynchronously: state=IDLE; ram_cs=0, ram_wr=0, ram_addr=0, ram_data=high-Z; rd_valid=0, rd_data=0, addr_err=0, busy=0; wr_ready=0, rd_ready=0; priority set so write wins next.
REQ-034 Reset asserted during WR, RD or RD_CAP SHALL abort the operation, and no rd_valid SHALL follow.
REQ-035 Ready outputs SHALL become 1 in the first cycle after rstn deasserts.

Verification
REQ-036 After reset, write (addr 0, 0xA5) then read addr 0 → rd_valid exactly one cycle, 2 edges after the read accept, rd_data=0xA5.
REQ-037 Write (63, 0x3C) then read 63 → rd_data=0x3C, addr_err never asserted.
REQ-038 First simultaneous wr(5, 0x11) and rd(5) after reset → write granted first and read returns 0x11; a second simultaneous pair → read granted first.
REQ-039 Writes 0x20..0x23 to addresses 10..13 back-to-back, then reads 10..13 → data matches in order, busy high during each op, ram_data high-Z outside WR.
REQ-040 rstn pulsed low during RD → ram_cs=0 and rd_data=0 immediately, no rd_valid, and the next read operates normally.
REQ-041 Instance with DEPTH=48: write addr 50 → wr_ready handshake completes, addr_err one-cycle pulse, ram_cs stays 0.
